// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: item select, multi-unit quantity, coin credit, change return.
// Optional per-item stock counters and SOLDOUT handling are enabled with `define VEND_STOCK_EN.
module vend_ctrl_param #(
  parameter int unsigned N_ITEMS    = 16,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned PRICE_W    = 10,
  parameter int unsigned QTY_W      = 7,
  parameter int unsigned MAX_QTY    = 99,
  parameter int unsigned SUM_W      = 17,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {N_ITEMS{10'd100}},
  parameter int unsigned STOCK_W    = 8,
  parameter int unsigned INIT_STOCK = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   item_sel,
  input  logic [SUM_W-1:0]   coin_val,
  input  logic               coin_vld,
  input  logic               qty_up,
  input  logic               qty_dn,
  input  logic               confirm,
  input  logic               cancel,
  output logic [SUM_W-1:0]   credit,
  output logic [QTY_W-1:0]   qty,
  output logic [SUM_W-1:0]   cost,
  output logic [SUM_W-1:0]   total_sales,
  output logic [SUM_W-1:0]   change_val,
  output logic               change_vld,
  output logic               dispense,
  output logic               coin_reject,
  output logic [2:0]         mode
);

  localparam int unsigned PROD_W = PRICE_W + QTY_W;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StPay      = 3'd2,
    StDispense = 3'd3,
    StChange   = 3'd4,
    StSoldout  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   credit_q, credit_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [QTY_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   item_q, item_d;
  logic [SUM_W-1:0]   total_q, total_d;
  logic [SUM_W-1:0]   change_val_q, change_val_d;
  logic               change_vld_q, change_vld_d;
  logic               dispense_q, dispense_d;
  logic               coin_reject_q, coin_reject_d;

  logic [SEL_W-1:0]   item_eff, item_cur;
  logic [PRICE_W-1:0] price_cur;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W:0]     coin_sum;
  logic               coin_ok;
  logic               sold_out;

  // Out-of-range selections fall back to item 0; SELECT previews the live selection.
  assign item_eff  = (32'(item_sel) < N_ITEMS) ? item_sel : '0;
  assign item_cur  = (state_q == StSelect) ? item_eff : item_q;
  assign price_cur = PRICES[32'(item_cur)*PRICE_W +: PRICE_W];
  assign prod      = PROD_W'(price_cur) * PROD_W'(qty_q);
  assign cost      = SUM_W'(prod);
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok   = !coin_sum[SUM_W];

`ifdef VEND_STOCK_EN
  logic [N_ITEMS*STOCK_W-1:0] stock_q;
  logic [STOCK_W-1:0]         stock_cur;

  assign stock_cur = stock_q[32'(item_cur)*STOCK_W +: STOCK_W];
  assign sold_out  = 32'(stock_cur) < 32'(qty_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stock_q <= {N_ITEMS{STOCK_W'(INIT_STOCK)}};
    end else if (state_q == StDispense && stock_cur != '0) begin
      stock_q[32'(item_q)*STOCK_W +: STOCK_W] <= stock_cur - STOCK_W'(1);
    end
  end
`else
  assign sold_out = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    qty_d         = qty_q;
    cnt_d         = cnt_q;
    item_d        = item_q;
    total_d       = total_q;
    change_val_d  = change_val_q;
    change_vld_d  = 1'b0;
    dispense_d    = 1'b0;
    coin_reject_d = coin_vld;
    unique case (state_q)
      StIdle: begin
        if (confirm) begin
          state_d = StSelect;
          qty_d   = QTY_W'(1);
        end
      end
      StSelect: begin
        if (cancel) begin
          state_d = StChange;
        end else if (confirm) begin
          item_d  = item_eff;
          state_d = sold_out ? StSoldout : StPay;
        end else if (qty_up) begin
          if (32'(qty_q) < MAX_QTY) qty_d = qty_q + QTY_W'(1);
        end else if (qty_dn) begin
          if (qty_q > QTY_W'(1)) qty_d = qty_q - QTY_W'(1);
        end
      end
      StPay: begin
        if (cancel) begin
          // A coin in the cancel cycle joins the refund.
          if (coin_vld && coin_ok) begin
            credit_d      = coin_sum[SUM_W-1:0];
            coin_reject_d = 1'b0;
          end
          state_d = StChange;
        end else if (credit_q >= cost) begin
          state_d  = StDispense;
          credit_d = credit_q - cost;
          total_d  = total_q + cost;
          cnt_d    = '0;
        end else if (coin_vld && coin_ok) begin
          credit_d      = coin_sum[SUM_W-1:0];
          coin_reject_d = 1'b0;
        end
      end
      StDispense: begin
        dispense_d = 1'b0 | 1'b1;
        if (32'(cnt_q) + 32'd1 >= 32'(qty_q)) begin
          state_d = StChange;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + QTY_W'(1);
        end
      end
      StChange: begin
        change_val_d = credit_q;
        change_vld_d = 1'b1;
        credit_d     = '0;
        state_d      = StIdle;
      end
      StSoldout: state_d = StSelect;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      qty_q         <= '0;
      cnt_q         <= '0;
      item_q        <= '0;
      total_q       <= '0;
      change_val_q  <= '0;
      change_vld_q  <= 1'b0;
      dispense_q    <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      qty_q         <= qty_d;
      cnt_q         <= cnt_d;
      item_q        <= item_d;
      total_q       <= total_d;
      change_val_q  <= change_val_d;
      change_vld_q  <= change_vld_d;
      dispense_q    <= dispense_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign credit      = credit_q;
  assign qty         = qty_q;
  assign total_sales = total_q;
  assign change_val  = change_val_q;
  assign change_vld  = change_vld_q;
  assign dispense    = dispense_q;
  assign coin_reject = coin_reject_q;
  assign mode        = state_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: a 4-item 17-bit instance and a small 8-bit instance
// share stimulus; the idle one is held in reset. Change values are scoreboarded.
module tb_vend_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  item_sel;
  logic [16:0] coin_val;
  logic        coin_vld, qty_up, qty_dn, confirm, cancel;

  logic [16:0] a_credit, a_cost, a_total, a_change_val;
  logic [6:0]  a_qty;
  logic        a_change_vld, a_dispense, a_coin_reject;
  logic [2:0]  a_mode;

  logic [7:0]  b_credit, b_cost, b_total, b_change_val;
  logic [6:0]  b_qty;
  logic        b_change_vld, b_dispense, b_coin_reject;
  logic [2:0]  b_mode;

  int checks = 0;
  int errors = 0;
  int a_disp_n = 0;
  int b_disp_n = 0;
  int n;
  int got;
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;

  localparam int BConfirm = 0;
  localparam int BCancel  = 1;
  localparam int BUp      = 2;
  localparam int BDn      = 3;

  always #5 clk = ~clk;

  vend_ctrl_param #(
    .N_ITEMS(4), .SEL_W(4), .PRICE_W(10), .QTY_W(7), .MAX_QTY(99), .SUM_W(17),
    .PRICES({10'd100, 10'd200, 10'd300, 10'd400}), .STOCK_W(8), .INIT_STOCK(10)
  ) u_dut (
    .clk(clk), .rst(rst_a), .item_sel(item_sel), .coin_val(coin_val), .coin_vld(coin_vld),
    .qty_up(qty_up), .qty_dn(qty_dn), .confirm(confirm), .cancel(cancel),
    .credit(a_credit), .qty(a_qty), .cost(a_cost), .total_sales(a_total),
    .change_val(a_change_val), .change_vld(a_change_vld), .dispense(a_dispense),
    .coin_reject(a_coin_reject), .mode(a_mode)
  );

  vend_ctrl_param #(
    .N_ITEMS(4), .SEL_W(4), .PRICE_W(10), .QTY_W(7), .MAX_QTY(99), .SUM_W(8),
    .PRICES({4{10'd50}}), .STOCK_W(8), .INIT_STOCK(2)
  ) u_sm (
    .clk(clk), .rst(rst_b), .item_sel(item_sel), .coin_val(coin_val[7:0]), .coin_vld(coin_vld),
    .qty_up(qty_up), .qty_dn(qty_dn), .confirm(confirm), .cancel(cancel),
    .credit(b_credit), .qty(b_qty), .cost(b_cost), .total_sales(b_total),
    .change_val(b_change_val), .change_vld(b_change_vld), .dispense(b_dispense),
    .coin_reject(b_coin_reject), .mode(b_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    case (b)
      BConfirm: confirm = 1'b1;
      BCancel:  cancel  = 1'b1;
      BUp:      qty_up  = 1'b1;
      default:  qty_dn  = 1'b1;
    endcase
    tick();
    confirm = 1'b0;
    cancel  = 1'b0;
    qty_up  = 1'b0;
    qty_dn  = 1'b0;
  endtask

  task automatic coin(input int v);
    coin_val = 17'(v);
    coin_vld = 1'b1;
    tick();
    coin_vld = 1'b0;
    coin_val = '0;
  endtask

  task automatic wait_idle(input bit use_b, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((use_b ? b_mode : a_mode) == 3'd0) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Scoreboard: every change strobe from the wide instance must match a queued refund.
  always @(negedge clk) begin
    if (!rst_a && a_change_vld) begin
      chk("a_change_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk("a_change_val", 32'(a_change_val), 32'(exp_v));
      end
    end
    if (a_dispense) a_disp_n++;
    if (b_dispense) b_disp_n++;
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    item_sel = '0; coin_val = '0;
    coin_vld = 1'b0; qty_up = 1'b0; qty_dn = 1'b0; confirm = 1'b0; cancel = 1'b0;
    repeat (2) tick();

    chk("rst_mode", 32'(a_mode), 0);
    chk("rst_credit", 32'(a_credit), 0);
    chk("rst_qty", 32'(a_qty), 0);
    chk("rst_cost", 32'(a_cost), 0);
    chk("rst_total", 32'(a_total), 0);
    chk("rst_change_val", 32'(a_change_val), 0);
    chk("rst_strobes", {29'd0, a_change_vld, a_dispense, a_coin_reject}, 0);

    rst_a = 1'b0;
    tick();
    coin(40);
    chk("idle_coin_reject", 32'(a_coin_reject), 1);
    chk("idle_coin_credit", 32'(a_credit), 0);

    // Quantity limits, then a zero refund on cancel in SELECT
    press(BConfirm);
    chk("sel_mode", 32'(a_mode), 1);
    chk("sel_qty_init", 32'(a_qty), 1);
    press(BDn);
    chk("qty_floor", 32'(a_qty), 1);
    repeat (120) press(BUp);
    chk("qty_ceiling", 32'(a_qty), 99);
    chk("cost_item0_q99", 32'(a_cost), 39600);
    exp_q.push_back(17'd0);
    press(BCancel);
    chk("cancel_sel_mode", 32'(a_mode), 4);
    tick();
    chk("cancel_sel_idle", 32'(a_mode), 0);

    // Basic purchase: item 2 (200) x3, coins 500 + 200
    a_disp_n = 0;
    press(BConfirm);
    item_sel = 4'd2;
    press(BUp);
    press(BUp);
    chk("buy_qty", 32'(a_qty), 3);
    chk("buy_cost", 32'(a_cost), 600);
    press(BConfirm);
    chk("buy_pay_mode", 32'(a_mode), 2);
    coin(500);
    chk("buy_credit1", 32'(a_credit), 500);
    exp_q.push_back(17'd100);
    coin(200);
    chk("buy_credit2", 32'(a_credit), 700);
    wait_idle(1'b0, n);
    chk("buy_latency", 32'(n), 5);
    chk("buy_dispense_n", 32'(a_disp_n), 3);
    chk("buy_total", 32'(a_total), 600);
    chk("buy_credit_cleared", 32'(a_credit), 0);

    // Cancel refund with a coin in the cancel cycle
    a_disp_n = 0;
    press(BConfirm);
    press(BUp);
    press(BConfirm);
    coin(250);
    chk("refund_credit", 32'(a_credit), 250);
    exp_q.push_back(17'd300);
    coin_val = 17'd50; coin_vld = 1'b1; cancel = 1'b1;
    tick();
    coin_vld = 1'b0; cancel = 1'b0; coin_val = '0;
    chk("refund_mode", 32'(a_mode), 4);
    tick();
    chk("refund_idle", 32'(a_mode), 0);
    chk("refund_no_dispense", 32'(a_disp_n), 0);
    chk("refund_total", 32'(a_total), 600);

    // Reset after the first dispense pulse
    item_sel = 4'd3;
    press(BConfirm);
    press(BUp);
    press(BUp);
    press(BConfirm);
    coin(300);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_dispense) begin
        got = 1;
        break;
      end
    end
    chk("rstmid_first_pulse", 32'(got), 1);
    rst_a = 1'b1;
    #1;
    chk("rstmid_mode", 32'(a_mode), 0);
    chk("rstmid_credit", 32'(a_credit), 0);
    chk("rstmid_qty", 32'(a_qty), 0);
    chk("rstmid_total", 32'(a_total), 0);
    chk("rstmid_change_val", 32'(a_change_val), 0);
    chk("rstmid_dispense", 32'(a_dispense), 0);
    repeat (3) tick();
    rst_a = 1'b0;
    repeat (4) tick();
    chk("rstmid_stays_idle", 32'(a_mode), 0);

    // Small instance: credit overflow
    rst_a = 1'b1;
    rst_b = 1'b0;
    tick();
    item_sel = 4'd0;
    press(BConfirm);
    repeat (4) press(BUp);
    chk("ovf_cost", 32'(b_cost), 250);
    press(BConfirm);
    chk("ovf_pay_mode", 32'(b_mode), 2);
    coin(200);
    chk("ovf_credit", 32'(b_credit), 200);
    coin(100);
    chk("ovf_reject", 32'(b_coin_reject), 1);
    chk("ovf_credit_held", 32'(b_credit), 200);
    press(BCancel);
    tick();
    chk("ovf_change_vld", 32'(b_change_vld), 1);
    chk("ovf_change_val", 32'(b_change_val), 200);
    chk("ovf_idle", 32'(b_mode), 0);

    // Stock handling on item 1
    item_sel = 4'd1;
    press(BConfirm);
    press(BUp);
    press(BUp);
`ifdef VEND_STOCK_EN
    press(BConfirm);
    chk("soldout_mode", 32'(b_mode), 5);
    tick();
    chk("soldout_back_sel", 32'(b_mode), 1);
    chk("soldout_qty_kept", 32'(b_qty), 3);
    press(BDn);
    press(BConfirm);
    chk("stock_pay_mode", 32'(b_mode), 2);
    b_disp_n = 0;
    coin(100);
    wait_idle(1'b1, n);
    chk("stock_dispense_n", 32'(b_disp_n), 2);
    press(BConfirm);
    press(BConfirm);
    chk("stock_empty_soldout", 32'(b_mode), 5);
    tick();
    chk("stock_empty_back_sel", 32'(b_mode), 1);
    press(BCancel);
    tick();
`else
    press(BConfirm);
    chk("nostock_to_pay", 32'(b_mode), 2);
    press(BCancel);
    tick();
    chk("nostock_idle", 32'(b_mode), 0);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
